// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and FSM state types for the multi-cycle ALU
package alu_pkg;

  localparam int W_ALU_SEL = 3;

  typedef enum logic [W_ALU_SEL-1:0] {
    ALU_ADD    = 3'b000,
    ALU_SUB    = 3'b001,
    ALU_MUL    = 3'b010,
    ALU_DIV    = 3'b011,
    ALU_REM    = 3'b100,
    ALU_PASS_A = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // Unassigned opcodes fold onto PASS_A.
  function automatic alu_op_e decode_op(input logic [W_ALU_SEL-1:0] sel);
    case (sel)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SUB;
      3'b010:  return ALU_MUL;
      3'b011:  return ALU_DIV;
      3'b100:  return ALU_REM;
      default: return ALU_PASS_A;
    endcase
  endfunction

endpackage

// File: rtl/alu_divider.sv
// rtl/alu_divider.sv - unsigned restoring divider, one quotient bit per cycle
module alu_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);

  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;

  // Dividend bits shift out of quo_q's top while quotient bits shift in below.
  always_comb begin
    partial = {rem_q, quo_q[WIDTH-1]};
    trial   = partial - {1'b0, div_q};
    fits    = ~trial[WIDTH];
    rem_d   = fits ? trial[WIDTH-1:0] : partial[WIDTH-1:0];
    quo_d   = {quo_q[WIDTH-2:0], fits};
  end

  // done marks the cycle whose edge retires the last bit; outputs are that bit's result.
  assign done      = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign quotient  = quo_d;
  assign remainder = rem_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      div_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      quo_q  <= dividend;
      rem_q  <= '0;
      div_q  <= divisor;
    end else if (busy_q) begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      cnt_q <= cnt_q + CW'(1);
      if (done) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle signed ALU with valid/ready handshake on both sides
module alu_mc #(
  parameter  int WIDTH     = 8,
  localparam int W_ALU_SEL = alu_pkg::W_ALU_SEL
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] bus_a,
  input  logic signed [WIDTH-1:0] bus_b,
  input  logic [W_ALU_SEL-1:0]    alu_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] alu_out,
  output logic                    zero,
  output logic                    negative,
  output logic                    overflow,
  output logic                    div_zero
);

  import alu_pkg::*;

  localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  alu_state_e              state_q;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic signed [WIDTH-1:0] res_q;
  logic                    ovf_q;
  logic                    dz_q;
  logic                    is_rem_q;
  logic                    a_neg_q;
  logic                    b_neg_q;
  logic                    div_ovf_q;

  alu_op_e                   op;
  logic                      is_divrem;
  logic                      start_div;
  logic signed [WIDTH-1:0]   sum;
  logic signed [WIDTH-1:0]   diff;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [WIDTH-1:0]   res_d;
  logic                      ovf_d;
  logic                      dz_d;
  logic [WIDTH-1:0]          a_abs;
  logic [WIDTH-1:0]          b_abs;
  logic                      div_done;
  logic [WIDTH-1:0]          div_quo;
  logic [WIDTH-1:0]          div_rem;
  logic [WIDTH-1:0]          quo_fix;
  logic [WIDTH-1:0]          rem_fix;

  assign op        = decode_op(alu_sel);
  assign is_divrem = (op == ALU_DIV) || (op == ALU_REM);
  assign start_div = in_valid && in_ready_q && is_divrem && (bus_b != '0);
  // -MIN_VAL wraps to the same pattern, which is exactly its unsigned magnitude.
  assign a_abs     = bus_a[WIDTH-1] ? WIDTH'(-bus_a) : bus_a;
  assign b_abs     = bus_b[WIDTH-1] ? WIDTH'(-bus_b) : bus_b;

  always_comb begin
    sum   = bus_a + bus_b;
    diff  = bus_a - bus_b;
    prod  = (2*WIDTH)'(bus_a) * (2*WIDTH)'(bus_b);
    res_d = '0;
    ovf_d = 1'b0;
    dz_d  = 1'b0;
    case (op)
      ALU_ADD: begin
        res_d = sum;
        ovf_d = (bus_a[WIDTH-1] == bus_b[WIDTH-1]) && (sum[WIDTH-1] != bus_a[WIDTH-1]);
      end
      ALU_SUB: begin
        res_d = diff;
        ovf_d = (bus_a[WIDTH-1] != bus_b[WIDTH-1]) && (diff[WIDTH-1] != bus_a[WIDTH-1]);
      end
      ALU_MUL: begin
        res_d = prod[WIDTH-1:0];
        ovf_d = prod[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){prod[WIDTH-1]}};
      end
      ALU_DIV, ALU_REM: begin
        dz_d = 1'b1;
      end
      default: begin
        res_d = bus_a;
      end
    endcase
  end

  alu_divider #(.WIDTH(WIDTH)) u_divider (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start_div),
    .dividend  (a_abs),
    .divisor   (b_abs),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign quo_fix = (a_neg_q ^ b_neg_q) ? WIDTH'(-div_quo) : div_quo;
  assign rem_fix = a_neg_q ? WIDTH'(-div_rem) : div_rem;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
      is_rem_q    <= 1'b0;
      a_neg_q     <= 1'b0;
      b_neg_q     <= 1'b0;
      div_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            if (start_div) begin
              state_q   <= ST_CALC;
              is_rem_q  <= (op == ALU_REM);
              a_neg_q   <= bus_a[WIDTH-1];
              b_neg_q   <= bus_b[WIDTH-1];
              div_ovf_q <= (op == ALU_DIV) && (bus_a == MIN_VAL) && (&bus_b);
            end else begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
              res_q       <= res_d;
              ovf_q       <= ovf_d;
              dz_q        <= dz_d;
            end
          end
        end
        ST_CALC: begin
          if (div_done) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
            res_q       <= is_rem_q ? rem_fix : quo_fix;
            ovf_q       <= div_ovf_q;
            dz_q        <= 1'b0;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign alu_out   = res_q;
  assign overflow  = ovf_q;
  assign div_zero  = dz_q;
  assign zero      = (res_q == '0);
  assign negative  = res_q[WIDTH-1];

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, datapath width in bits (legal range 4..32).
REQ-002 SHALL have localparam W_ALU_SEL, fixed 3, opcode width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  operand/opcode presented.
REQ-006 SHALL have port in_ready  output  1  block accepts a new operation.
REQ-007 SHALL have port bus_a  input  WIDTH signed  operand A.
REQ-008 SHALL have port bus_b  input  WIDTH signed  operand B.
REQ-009 SHALL have port alu_sel  input  W_ALU_SEL  opcode.
REQ-010 SHALL have port out_valid  output  1  result held and valid.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port alu_out  output  WIDTH signed  result.
REQ-013 SHALL have ports zero, negative, overflow, div_zero  output  1 each  result flags.

Function
REQ-014 SHALL decode opcodes: 000 ADD, 001 SUB, 010 MUL (low WIDTH bits of product), 011 DIV, 100 REM, all others PASS_A.
REQ-015 SHALL run FSM IDLE -> (CALC for DIV/REM with nonzero bus_b) -> DONE -> IDLE.
REQ-016 SHALL drive in_ready = 1 only in IDLE; an operation is accepted on an edge where in_valid & in_ready.
REQ-017 SHALL, for ADD/SUB/MUL/PASS_A and DIV/REM with bus_b == 0, register the result and enter DONE on the accepting edge (out_valid high the following cycle, latency 1).
REQ-018 SHALL latch operands on acceptance; bus_a/bus_b/alu_sel changes after acceptance have no effect.
REQ-019 SHALL compute DIV/REM iteratively, one quotient bit per cycle, WIDTH cycles in CALC, then enter DONE (out_valid at latency WIDTH+1).
REQ-020 SHALL truncate signed DIV toward zero; REM sign follows bus_a; |REM| < |bus_b|.
REQ-021 SHALL, for DIV/REM with bus_b == 0, output 0 with div_zero = 1.
REQ-022 SHALL set overflow: ADD/SUB on signed overflow; MUL when full 2*WIDTH product is not representable in WIDTH signed bits; DIV of -2^(WIDTH-1) by -1 (result -2^(WIDTH-1)); else 0.
REQ-023 SHALL set REM of -2^(WIDTH-1) by -1 to 0 with overflow = 0.
REQ-024 SHALL derive zero = (alu_out == 0) and negative = alu_out[WIDTH-1] from the registered result.
REQ-025 SHALL hold alu_out and all flags stable while out_valid & !out_ready.
REQ-026 SHALL leave DONE for IDLE on the edge where out_valid & out_ready; in_ready rises the next cycle.
REQ-027 SHALL keep alu_out and flags at last values when out_valid is 0 (no meaning to consumer).

Reset
REQ-028 SHALL on rstn low immediately force state IDLE, out_valid 0, alu_out 0, overflow 0, div_zero 0 (zero 1, negative 0 by derivation).
REQ-029 SHALL abort any in-progress division on reset; no result is produced for it.
REQ-030 SHALL drive in_ready 1 in the first cycle after rstn deasserts.

Structure
REQ-031 SHALL place alu_op_e enum (ADD, SUB, MUL, DIV, REM, PASS_A), W_ALU_SEL and FSM state enum in package alu_pkg.
REQ-032 SHALL implement the iterative unsigned restoring divider as sub-module alu_divider (start, WIDTH-cycle run, quotient/remainder, done); sign fix-up stays in alu_mc.

Verification (WIDTH = 8)
REQ-033 SHALL test ADD 100 + 50 -> alu_out -106, overflow 1, negative 1, out_valid one cycle after acceptance.
REQ-034 SHALL test DIV -7 / 2 -> -3 and REM -7 % 2 -> -1, out_valid exactly 9 cycles after acceptance, in_ready 0 throughout.
REQ-035 SHALL test DIV 5 / 0 -> alu_out 0, div_zero 1, zero 1, latency 1; and DIV -128 / -1 -> -128, overflow 1.
REQ-036 SHALL test MUL 16 * 8 -> alu_out -128, overflow 1; MUL -4 * 3 -> -12, overflow 0.
REQ-037 SHALL test backpressure: out_ready low 3 cycles after SUB 3 - 5 -> alu_out -2 and flags stable, in_ready 0, then out_ready high -> in_ready 1 next cycle.
REQ-038 SHALL test rstn low in cycle 4 of a DIV -> out_valid 0 immediately, in_ready 1 after release, no stale result emitted.
